extram_ctrl: RTL and testbench

EXTRAM_CTRL -- requirements
Module: extram_ctrl

---
 rtl/extram_ctrl.sv | 107 ++++++++++
 tb/tb_extram_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/extram_ctrl.sv
// External SRAM controller: one SRAM slot per clock, shared between a video fetch port
// (absolute priority) and a Wishbone CPU port served through a three-state FSM.
module extram_ctrl (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [18:0] ADR_I,
  input  logic [7:0]  DAT_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  output logic [7:0]  DAT_O,
  input  logic        I_vid_req,
  input  logic [18:0] I_vid_adr,
  output logic [7:0]  O_vid_dat,
  output logic [18:0] O_sram_adr,
  output logic [7:0]  O_sram_dat,
  output logic        O_sram_dat_oe,
  input  logic [7:0]  I_sram_dat,
  output logic        O_sram_oe_n,
  output logic        O_sram_we_n
);

  typedef enum logic [1:0] {StIdle, StPend, StDone} state_e;

  state_e      state_q, state_d;
  logic [18:0] adr_q;
  logic [7:0]  dat_q;
  logic        we_q;
  logic [18:0] last_adr_q;
  logic        vid_slot;
  logic        cpu_slot;

  assign vid_slot   = I_vid_req;
  assign cpu_slot   = (state_q == StPend) && !I_vid_req;
  assign O_sram_dat = dat_q;

  // FSM state register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a video request in PEND stalls the CPU for that slot
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (STB_I && !ACK_O) state_d = StPend;
      StPend:  if (!I_vid_req) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Latch the CPU request when it is accepted out of IDLE
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
    end else if ((state_q == StIdle) && STB_I) begin
      adr_q <= ADR_I;
      dat_q <= DAT_I;
      we_q  <= WE_I;
    end
  end

  // FSM/slot outputs; reset gates the pad controls without waiting for an edge
  always_comb begin
    ACK_O         = (state_q == StDone);
    O_sram_adr    = last_adr_q;
    O_sram_oe_n   = 1'b1;
    O_sram_we_n   = 1'b1;
    O_sram_dat_oe = 1'b0;
    if (RST_I) begin
      ACK_O      = 1'b0;
      O_sram_adr = '0;
    end else if (vid_slot) begin
      O_sram_adr  = I_vid_adr;
      O_sram_oe_n = 1'b0;
    end else if (cpu_slot) begin
      O_sram_adr = adr_q;
      if (we_q) begin
        O_sram_we_n   = 1'b0;
        O_sram_dat_oe = 1'b1;
      end else begin
        O_sram_oe_n = 1'b0;
      end
    end
  end

  // Read data capture at the slot's closing edge; idle slots hold the last address
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      DAT_O      <= '0;
      O_vid_dat  <= '0;
      last_adr_q <= '0;
    end else begin
      last_adr_q <= O_sram_adr;
      if (vid_slot) O_vid_dat <= I_sram_dat;
      if (cpu_slot && !we_q) DAT_O <= I_sram_dat;
    end
  end

endmodule

// File: tb/tb_extram_ctrl.sv
// Self-checking bench for extram_ctrl: SRAM array model, video generator, CPU driver
// and an expected-memory reference compared against video and CPU read data.
module tb_extram_ctrl;

  logic        CLK_I, RST_I;
  logic [18:0] ADR_I;
  logic [7:0]  DAT_I;
  logic        STB_I, WE_I;
  logic        ACK_O;
  logic [7:0]  DAT_O;
  logic        I_vid_req;
  logic [18:0] I_vid_adr;
  logic [7:0]  O_vid_dat;
  logic [18:0] O_sram_adr;
  logic [7:0]  O_sram_dat;
  logic        O_sram_dat_oe;
  logic [7:0]  I_sram_dat;
  logic        O_sram_oe_n, O_sram_we_n;

  extram_ctrl dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .STB_I(STB_I), .WE_I(WE_I),
    .ACK_O(ACK_O), .DAT_O(DAT_O), .I_vid_req(I_vid_req), .I_vid_adr(I_vid_adr),
    .O_vid_dat(O_vid_dat), .O_sram_adr(O_sram_adr), .O_sram_dat(O_sram_dat),
    .O_sram_dat_oe(O_sram_dat_oe), .I_sram_dat(I_sram_dat), .O_sram_oe_n(O_sram_oe_n),
    .O_sram_we_n(O_sram_we_n)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Power-on contents shared by the SRAM model and the reference
  function automatic logic [7:0] init_byte(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]} ^ 8'h3C;
  endfunction

  logic [7:0] phys_mem [logic [18:0]];
  logic [7:0] ref_mem  [logic [18:0]];

  function automatic logic [7:0] phys_rd(input logic [18:0] a);
    if (phys_mem.exists(a)) return phys_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [18:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  int cyc = 0;
  always @(posedge CLK_I) cyc <= cyc + 1;

  // SRAM model read path
  always @(O_sram_adr, O_sram_oe_n, negedge CLK_I)
    I_sram_dat <= O_sram_oe_n ? 8'hEE : phys_rd(O_sram_adr);

  // Mid-cycle monitor: SRAM writes, slot counters, video data check
  int          viol = 0, we_low = 0, oe_low = 0;
  logic [18:0] w_adr;
  logic [7:0]  w_dat;
  logic        w_oe;
  always @(negedge CLK_I) begin
    logic [18:0] a;
    if (!RST_I) begin
      if (!O_sram_we_n) begin
        phys_mem[O_sram_adr] = O_sram_dat;
        we_low++;
        w_adr = O_sram_adr;
        w_dat = O_sram_dat;
        w_oe  = O_sram_dat_oe;
        if (I_vid_req) viol++;
      end
      if (!O_sram_oe_n && !I_vid_req) oe_low++;
      if (I_vid_req) begin
        a = I_vid_adr;
        check("vid_adr", {13'b0, O_sram_adr}, {13'b0, a});
        @(posedge CLK_I);
        #1;
        check("vid_dat", {24'b0, O_vid_dat}, {24'b0, ref_rd(a)});
      end
    end
  end

  // Video generator: 0 off/one-shot, 1 every other cycle sequential, 2 random
  int          vid_mode = 0;
  logic [18:0] vid_base = '0;
  int          shot_cyc = -1;
  initial begin
    int          vcnt;
    logic [31:0] r;
    vcnt      = 0;
    I_vid_req = 1'b0;
    I_vid_adr = '0;
    forever begin
      @(posedge CLK_I);
      #1;
      if (vid_mode == 1) begin
        if (I_vid_req) I_vid_req = 1'b0;
        else begin
          I_vid_req = 1'b1;
          I_vid_adr = vid_base + 19'(vcnt);
          vcnt++;
        end
      end else if (vid_mode == 2) begin
        r = $urandom();
        if (!I_vid_req && r[31]) begin
          I_vid_req = 1'b1;
          I_vid_adr = {3'b000, r[15:0]};
        end else I_vid_req = 1'b0;
      end else if (cyc == shot_cyc) begin
        I_vid_req = 1'b1;
        I_vid_adr = 19'h20005;
      end else I_vid_req = 1'b0;
    end
  end

  // One Wishbone access; lat counts edges from STB_I acceptance to the ACK_O sampling edge
  task automatic cpu_access(input bit we, input logic [18:0] adr, input logic [7:0] dat,
                            input bit stall, output logic [7:0] rd, output int lat);
    int n;
    bit got;
    @(posedge CLK_I);
    #1;
    ADR_I = adr;
    DAT_I = dat;
    WE_I  = we;
    STB_I = 1'b1;
    if (stall) shot_cyc = cyc + 1;
    n   = 0;
    got = 0;
    rd  = '0;
    while (!got && n < 10) begin
      @(posedge CLK_I);
      #1;
      n++;
      if (ACK_O) begin
        got = 1;
        rd  = DAT_O;
      end
    end
    lat = n + 1;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge CLK_I);
    #1;
    STB_I = 1'b0;
    if (got && we) ref_mem[adr] = dat;
  endtask

  initial begin
    logic [7:0]  rd, exp;
    logic [18:0] a;
    logic [31:0] r;
    int          lat, w0, o0;
    RST_I = 1'b1;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    ADR_I = '0;
    DAT_I = '0;
    repeat (3) @(posedge CLK_I);
    #1;
    check("rst_ack", {31'b0, ACK_O}, 32'd0);
    check("rst_dat", {24'b0, DAT_O}, 32'd0);
    check("rst_vdat", {24'b0, O_vid_dat}, 32'd0);
    check("rst_we_n", {31'b0, O_sram_we_n}, 32'd1);
    check("rst_oe_n", {31'b0, O_sram_oe_n}, 32'd1);
    check("rst_dat_oe", {31'b0, O_sram_dat_oe}, 32'd0);
    check("rst_adr", {13'b0, O_sram_adr}, 32'd0);
    check("rst_sdat", {24'b0, O_sram_dat}, 32'd0);
    RST_I = 1'b0;

    // Directed write then read
    w0 = we_low;
    cpu_access(1, 19'h20000, 8'h5A, 0, rd, lat);
    check("wr_lat", lat, 3);
    check("wr_cycles", we_low - w0, 1);
    check("wr_adr", {13'b0, w_adr}, 32'h20000);
    check("wr_dat", {24'b0, w_dat}, 32'h5A);
    check("wr_oe", {31'b0, w_oe}, 32'd1);
    check("idle_adr", {13'b0, O_sram_adr}, 32'h20000);
    check("idle_oe_n", {31'b0, O_sram_oe_n}, 32'd1);
    o0 = oe_low;
    cpu_access(0, 19'h20000, 8'h00, 0, rd, lat);
    check("rd_dat", {24'b0, rd}, 32'h5A);
    check("rd_lat", lat, 3);
    check("rd_oe_cycles", oe_low - o0, 1);

    // Sequential video fetches at max rate
    vid_base = 19'h20000;
    vid_mode = 1;
    repeat (32) @(posedge CLK_I);
    vid_mode = 0;
    repeat (3) @(posedge CLK_I);

    // CPU read colliding with video in PEND
    cpu_access(0, 19'h20000, 8'h00, 1, rd, lat);
    check("stall_dat", {24'b0, rd}, 32'h5A);
    check("stall_lat", lat, 4);

    // Reset during a write slot
    @(posedge CLK_I);
    #1;
    ADR_I = 19'h20010;
    DAT_I = 8'hC3;
    WE_I  = 1'b1;
    STB_I = 1'b1;
    @(posedge CLK_I);
    #1;
    check("pre_rst_we_n", {31'b0, O_sram_we_n}, 32'd0);
    RST_I = 1'b1;
    #1;
    check("async_we_n", {31'b0, O_sram_we_n}, 32'd1);
    check("async_dat_oe", {31'b0, O_sram_dat_oe}, 32'd0);
    STB_I = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK_I);
      #1;
      check("rst_no_ack", {31'b0, ACK_O}, 32'd0);
    end
    check("rst_mid_adr", {13'b0, O_sram_adr}, 32'd0);
    RST_I = 1'b0;
    cpu_access(0, 19'h20010, 8'h00, 0, rd, lat);
    check("post_rst_dat", {24'b0, rd}, {24'b0, init_byte(19'h20010)});
    check("post_rst_lat", lat, 3);

    // Random CPU traffic against random video
    vid_mode = 2;
    for (int i = 0; i < 40; i++) begin
      r   = $urandom();
      a   = {3'b100, r[15:0]};
      exp = ref_rd(a);
      w0  = we_low;
      cpu_access(r[16], a, r[31:24], 0, rd, lat);
      check("rand_lat_ok", {31'b0, (lat >= 3 && lat <= 4)}, 32'd1);
      if (r[16]) check("rand_wr_cycles", we_low - w0, 1);
      else check("rand_rd", {24'b0, rd}, {24'b0, exp});
    end

    // Back-to-back writes under continuous video
    vid_base = 19'h10000;
    vid_mode = 1;
    for (int i = 0; i < 10; i++) begin
      cpu_access(1, 19'h30000 + 19'(i), 8'(8'h90 + i), 0, rd, lat);
      check("maxrate_lat_ok", {31'b0, (lat >= 3 && lat <= 4)}, 32'd1);
    end
    cpu_access(0, 19'h30003, 8'h00, 0, rd, lat);
    check("maxrate_rd", {24'b0, rd}, 32'h93);
    vid_mode = 0;
    repeat (3) @(posedge CLK_I);
    check("we_vs_vid", viol, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
